// File: rtl/monster_sprite_renderer_if.sv
// Raster, position, colour and sprite-ROM signals between the pixel pipeline and the monster renderer.
// The slave modport is the renderer; the master modport is whatever drives the raster and models the ROM.
interface monster_sprite_renderer_if #(
  parameter int H_W = 10,
  parameter int V_W = 10
);
  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           video_on;
  logic           frame_start;
  logic [H_W-1:0] mon_x;
  logic [V_W-1:0] mon_y;
  logic [11:0]    body_color;
  logic           fright;
  logic           fright_blink;
  logic [5:0]     rom_x;
  logic [5:0]     rom_y;
  logic [2:0]     rom_pixel;
  logic [11:0]    rgb;
  logic           sprite_hit;

  modport master (
    output h_cnt, v_cnt, video_on, frame_start, mon_x, mon_y,
           body_color, fright, fright_blink, rom_pixel,
    input  rom_x, rom_y, rgb, sprite_hit
  );

  modport slave (
    input  h_cnt, v_cnt, video_on, frame_start, mon_x, mon_y,
           body_color, fright, fright_blink, rom_pixel,
    output rom_x, rom_y, rgb, sprite_hit
  );
endinterface

// File: rtl/monster_sprite_renderer.sv
// Monster sprite renderer: raster -> ROM address (stage 1), ROM code -> RGB/hit (stage 3), 3-cycle latency.
// Define MONSTER_SCALE2_EN to draw the sprite at 2x (48x48 box, address = offset/2).
module monster_sprite_renderer #(
  parameter int          H_W          = 10,
  parameter int          V_W          = 10,
  parameter int          SPR_SIZE     = 24,
  parameter int          BLINK_SHIFT  = 4,
  parameter logic [11:0] C_EYE        = 12'hFFF,
  parameter logic [11:0] C_PUPIL      = 12'h22F,
  parameter logic [11:0] C_FRIGHT     = 12'h00F,
  parameter logic [11:0] C_FRIGHT_ALT = 12'hFFF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  monster_sprite_renderer_if.slave    bus
);

`ifdef MONSTER_SCALE2_EN
  localparam int BOX = 2 * SPR_SIZE;
`else
  localparam int BOX = SPR_SIZE;
`endif
  localparam logic [H_W-1:0] BOX_H = H_W'(BOX);
  localparam logic [V_W-1:0] BOX_V = V_W'(BOX);

  logic [H_W-1:0]       r_pos_x;
  logic [V_W-1:0]       r_pos_y;
  logic [BLINK_SHIFT:0] r_frame_cnt;
  logic                 r_v1;
  logic                 r_v2;
  logic [5:0]           r_rom_x;
  logic [5:0]           r_rom_y;
  logic [11:0]          r_rgb;
  logic                 r_hit;

  logic [H_W-1:0]       w_dx;
  logic [V_W-1:0]       w_dy;
  logic                 w_in_box;
  logic [5:0]           w_rx;
  logic [5:0]           w_ry;
  logic [11:0]          w_rgb;
  logic                 w_opaque;

  // Unsigned offsets; the >= guards stop a wrapped difference from looking in-box near the counter top.
  always_comb begin
    w_dx     = bus.h_cnt - r_pos_x;
    w_dy     = bus.v_cnt - r_pos_y;
    w_in_box = bus.video_on
             && (bus.h_cnt >= r_pos_x) && (w_dx < BOX_H)
             && (bus.v_cnt >= r_pos_y) && (w_dy < BOX_V);
`ifdef MONSTER_SCALE2_EN
    w_rx = w_dx[6:1];
    w_ry = w_dy[6:1];
`else
    w_rx = w_dx[5:0];
    w_ry = w_dy[5:0];
`endif
  end

  always_comb begin
    w_rgb    = '0;
    w_opaque = 1'b0;
    case (bus.rom_pixel)
      3'd0: begin
        w_opaque = 1'b1;
        if (!bus.fright)
          w_rgb = bus.body_color;
        else if (bus.fright_blink && r_frame_cnt[BLINK_SHIFT])
          w_rgb = C_FRIGHT_ALT;
        else
          w_rgb = C_FRIGHT;
      end
      3'd2: begin
        w_opaque = 1'b1;
        w_rgb    = C_EYE;
      end
      3'd3: begin
        w_opaque = 1'b1;
        w_rgb    = bus.fright ? C_FRIGHT_ALT : C_PUPIL;
      end
      default: begin
        w_opaque = 1'b0;
        w_rgb    = '0;
      end
    endcase
  end

  // Stage 1 reads the old latched position, so a frame_start on a visible pixel only affects later pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos_x     <= '0;
      r_pos_y     <= '0;
      r_frame_cnt <= '0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_rom_x     <= '0;
      r_rom_y     <= '0;
      r_rgb       <= '0;
      r_hit       <= 1'b0;
    end else begin
      if (bus.frame_start) begin
        r_pos_x     <= bus.mon_x;
        r_pos_y     <= bus.mon_y;
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      r_v1    <= w_in_box;
      r_rom_x <= w_in_box ? w_rx : '0;
      r_rom_y <= w_in_box ? w_ry : '0;
      r_v2    <= r_v1;
      r_hit   <= r_v2 && w_opaque;
      r_rgb   <= (r_v2 && w_opaque) ? w_rgb : '0;
    end
  end

  assign bus.rom_x      = r_rom_x;
  assign bus.rom_y      = r_rom_y;
  assign bus.rgb        = r_rgb;
  assign bus.sprite_hit = r_hit;

endmodule
